// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bus: groups the decode/hazard inputs and the pipeline
// enable, state and performance-counter outputs of hazard_sequencer.
//   master : pipeline side (drives instruction/hazard info, receives enables)
//   slave  : hazard_sequencer side
// Signals:
//   ifid_instr[31:0]  instruction in IF/ID
//   idex_memread      ID/EX instruction is a load
//   idex_rd[4:0]      ID/EX destination register
//   ex_branch_taken   branch/jump resolved taken in EX
//   mem_busy          data memory not ready
//   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold : pipeline controls
//   state[1:0]        FSM state (00 RUN, 01 LU_STALL, 10 FREEZE)
//   stall_cycles, flush_count : saturating performance counters
interface hazard_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      ifid_instr;
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ifid_instr, idex_memread, idex_rd, ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
    input  state, stall_cycles, flush_count
  );

  modport slave (
    input  ifid_instr, idex_memread, idex_rd, ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
    output state, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage RISC-V core.
// Decides each cycle whether PC and IF/ID advance, stall or flush, and whether
// the back end freezes. Handles multi-cycle load-use stalls, taken-branch
// flushes and data-memory wait freezes, and keeps saturating stall/flush
// counters.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : hazard_sequencer_if.slave (inputs, enables, state, counters)
// Enables are combinational from state and inputs; state and counters update
// one cycle later.
module hazard_sequencer #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } state_t;

  localparam logic [2:0] LU_REM = 3'(LU_STALL_CYCLES - 1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Register-source decode
  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2, hz;
  logic       unused_bits;

  assign opcode      = bus.ifid_instr[6:0];
  assign rs1         = bus.ifid_instr[19:15];
  assign rs2         = bus.ifid_instr[24:20];
  assign unused_bits = ^{bus.ifid_instr[31:25], bus.ifid_instr[14:7]};

  assign uses_rs1 = !(opcode == 7'b0110111 || opcode == 7'b0010111 ||
                      opcode == 7'b1101111);
  assign uses_rs2 = (opcode == 7'b0110011 || opcode == 7'b0100011 ||
                     opcode == 7'b1100011);
  assign hz = bus.idex_memread && (bus.idex_rd != 5'd0) &&
              ((uses_rs1 && rs1 == bus.idex_rd) ||
               (uses_rs2 && rs2 == bus.idex_rd));

  // Leaving FREEZE behaves exactly like the state that was frozen.
  state_t eff_state;
  assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (eff_state == LU_STALL || (eff_state == RUN && hz)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ret_d   = ret_q;
    if (bus.mem_busy) begin
      // Frozen cycles leave rem untouched so the stall penalty is preserved.
      if (state_q != FREEZE) begin
        state_d = FREEZE;
        ret_d   = state_q;
      end
    end else begin
      case (eff_state)
        RUN: begin
          state_d = RUN;
          if (!bus.ex_branch_taken && hz && LU_STALL_CYCLES > 1) begin
            state_d = LU_STALL;
            rem_d   = LU_REM;
          end
        end
        LU_STALL: begin
          if (bus.ex_branch_taken) begin
            state_d = RUN;
            rem_d   = '0;
          end else if (rem_q == 3'd1) begin
            state_d = RUN;
            rem_d   = '0;
          end else begin
            state_d = LU_STALL;
            rem_d   = rem_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && stall_q != '1) stall_d = stall_q + 1'b1;
    if (ifid_flush && flush_q != '1) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      rem_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.pipe_hold    = pipe_hold;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: two instances (LU_STALL_CYCLES=1 and
// =3) share the same stimulus; each expected vector carries a mask selecting
// which instance(s) it applies to.
module tb_hazard_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        mem_busy = 1'b0;
  logic        br = 1'b0;
  logic        memread = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] instr = 32'h0000_0013;

  hazard_sequencer_if #(.CNT_W(16)) if1 ();
  hazard_sequencer_if #(.CNT_W(16)) if3 ();

  assign if1.ifid_instr      = instr;
  assign if1.idex_memread    = memread;
  assign if1.idex_rd         = rd;
  assign if1.ex_branch_taken = br;
  assign if1.mem_busy        = mem_busy;
  assign if3.ifid_instr      = instr;
  assign if3.idex_memread    = memread;
  assign if3.idex_rd         = rd;
  assign if3.ex_branch_taken = br;
  assign if3.mem_busy        = mem_busy;

  hazard_sequencer #(.LU_STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  hazard_sequencer #(.LU_STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  // Output classes as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
  localparam logic [4:0] C_NORM  = 5'b11000;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_RST   = 5'b00110;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADD_HZ = 32'h0062_8533; // add x10,x5,x6
  localparam logic [31:0] ADD_R0 = 32'h0002_8533;
  localparam logic [31:0] LUI    = 32'h0002_80B7; // lui x1, rs1 field = 5

  typedef struct packed {
    logic [1:0]  mask;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t  sq[$];
  string nq[$];
  int    checks = 0;
  int    failures = 0;

  task automatic step(input string nm, input logic rs, input logic mb,
                      input logic b, input logic mr, input logic [4:0] d,
                      input logic [31:0] ins, input logic [1:0] mask,
                      input logic [4:0] ctl, input logic [1:0] st,
                      input int stl, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rs;
    mem_busy = mb;
    br       = b;
    memread  = mr;
    rd       = d;
    instr    = ins;
    if (mask != 2'b00) begin
      e.mask  = mask;
      e.ctl   = ctl;
      e.st    = st;
      e.stall = 16'(stl);
      e.flush = 16'(fl);
      sq.push_back(e);
      nq.push_back(nm);
    end
  endtask

  // Monitor: every cycle's outputs are sampled on the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    logic [38:0] act, req;
    if (sq.size() != 0) begin
      e  = sq.pop_front();
      nm = nq.pop_front();
      req = {e.ctl, e.st, e.stall, e.flush};
      for (int k = 0; k < 2; k++) begin
        if (e.mask[k]) begin
          if (k == 0)
            act = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_bubble,
                   if1.pipe_hold, if1.state, if1.stall_cycles, if1.flush_count};
          else
            act = {if3.pc_write, if3.ifid_write, if3.ifid_flush, if3.idex_bubble,
                   if3.pipe_hold, if3.state, if3.stall_cycles, if3.flush_count};
          checks++;
          if (act !== req) begin
            failures++;
            $display("FAIL %s lu%0d ctl/state/stall/flush actual=%b/%b/%0d/%0d required=%b/%b/%0d/%0d",
                     nm, (k == 0) ? 1 : 3, act[38:34], act[33:32], act[31:16], act[15:0],
                     req[38:34], req[33:32], req[31:16], req[15:0]);
          end
        end
      end
    end
  end

  initial begin
    int waited;
    // Reset and common checks (both instances)
    step("rst0",   1, 0, 0, 0, 5'd0, NOP,    2'b00, C_RST,   2'd0, 0, 0);
    step("rst",    1, 0, 0, 0, 5'd0, NOP,    2'b11, C_RST,   2'd0, 0, 0);
    step("idle",   0, 0, 0, 0, 5'd0, NOP,    2'b11, C_NORM,  2'd0, 0, 0);
    step("rd0",    0, 0, 0, 1, 5'd0, ADD_R0, 2'b11, C_NORM,  2'd0, 0, 0);
    step("lui",    0, 0, 0, 1, 5'd5, LUI,    2'b11, C_NORM,  2'd0, 0, 0);
    step("nofalse",0, 0, 0, 0, 5'd0, NOP,    2'b11, C_NORM,  2'd0, 0, 0);
    step("brhz",   0, 0, 1, 1, 5'd5, ADD_HZ, 2'b11, C_FLUSH, 2'd0, 0, 0);
    step("postbr", 0, 0, 0, 0, 5'd0, NOP,    2'b11, C_NORM,  2'd0, 0, 1);
    // Single-cycle load-use (LU_STALL_CYCLES=1 only)
    step("lu1",    0, 0, 0, 1, 5'd5, ADD_HZ, 2'b01, C_STALL, 2'd0, 0, 1);
    step("lu1post",0, 0, 0, 0, 5'd0, NOP,    2'b01, C_NORM,  2'd0, 1, 1);
    // Re-reset both instances
    step("rst0b",  1, 0, 0, 0, 5'd0, NOP,    2'b00, C_RST,   2'd0, 0, 0);
    step("rstb",   1, 0, 0, 0, 5'd0, NOP,    2'b11, C_RST,   2'd0, 0, 0);
    // Multi-cycle stall (LU_STALL_CYCLES=3)
    step("m1",     0, 0, 0, 1, 5'd5, ADD_HZ, 2'b10, C_STALL, 2'd0, 0, 0);
    step("m2",     0, 0, 0, 0, 5'd0, ADD_HZ, 2'b10, C_STALL, 2'd1, 1, 0);
    step("m3",     0, 0, 0, 0, 5'd0, ADD_HZ, 2'b10, C_STALL, 2'd1, 2, 0);
    step("m4",     0, 0, 0, 0, 5'd0, NOP,    2'b10, C_NORM,  2'd0, 3, 0);
    // Freeze mid-stall
    step("f1",     0, 0, 0, 1, 5'd5, ADD_HZ, 2'b10, C_STALL, 2'd0, 3, 0);
    step("f2",     0, 1, 0, 0, 5'd0, ADD_HZ, 2'b10, C_HOLD,  2'd1, 4, 0);
    step("f3",     0, 1, 0, 0, 5'd0, ADD_HZ, 2'b10, C_HOLD,  2'd2, 5, 0);
    step("f4",     0, 0, 0, 0, 5'd0, ADD_HZ, 2'b10, C_STALL, 2'd2, 6, 0);
    step("f5",     0, 0, 0, 0, 5'd0, ADD_HZ, 2'b10, C_STALL, 2'd1, 7, 0);
    step("f6",     0, 0, 0, 0, 5'd0, NOP,    2'b10, C_NORM,  2'd0, 8, 0);
    // Reset mid-stall
    step("r1",     0, 0, 0, 1, 5'd5, ADD_HZ, 2'b10, C_STALL, 2'd0, 8, 0);
    step("r2",     1, 0, 0, 0, 5'd0, ADD_HZ, 2'b10, C_RST,   2'd1, 9, 0);
    step("r3",     0, 0, 0, 0, 5'd0, NOP,    2'b10, C_NORM,  2'd0, 0, 0);
    step("r4",     0, 0, 0, 0, 5'd0, NOP,    2'b10, C_NORM,  2'd0, 0, 0);

    waited = 0;
    while (sq.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (sq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. Sits beside the control and forwarding units.
- Decides each cycle whether PC and IF/ID advance, stall or flush, and whether the back end freezes.
- Handles load-use stalls (multi-cycle via FSM), taken-branch flushes and data-memory wait freezes.
- Keeps saturating stall and flush counters for performance checks.

Parameters:
- LU_STALL_CYCLES, 1, number of stall cycles per load-use hazard; legal range 1..7.
- CNT_W, 16, width of the performance counters.

Ports:
- clk in 1: single clock, all state updates on the rising edge.
- reset in 1: synchronous, active-high.
- ifid_instr in 32: instruction currently in IF/ID.
- idex_memread in 1: instruction in ID/EX is a load.
- idex_rd in 5: destination register of the ID/EX instruction.
- ex_branch_taken in 1: branch/jump resolved taken in EX this cycle.
- mem_busy in 1: data memory not ready; the whole pipeline must hold.
- pc_write out 1: PC load enable.
- ifid_write out 1: IF/ID load enable.
- ifid_flush out 1: clear IF/ID to NOP.
- idex_bubble out 1: zero all control fields written into ID/EX.
- pipe_hold out 1: hold ID/EX, EX/MEM and MEM/WB.
- state out 2: FSM state (00 RUN, 01 LU_STALL, 10 FREEZE).
- stall_cycles out CNT_W: count of cycles with pc_write=0, excluding reset.
- flush_count out CNT_W: count of cycles with ifid_flush=1, excluding reset.

Behaviour:
- Register-source decode from ifid_instr:
  - Fields: opcode=[6:0], rs1=[19:15], rs2=[24:20].
  - uses_rs1 is 1 unless opcode is 0110111, 0010111 or 1101111.
  - uses_rs2 is 1 only for opcode 0110011, 0100011 or 1100011.
  - hz = idex_memread & (idex_rd!=0) & ((uses_rs1 & rs1==idex_rd) | (uses_rs2 & rs2==idex_rd)).
- Outputs are combinational (Mealy) from state and inputs. Output classes, as pc_write/ifid_write/ifid_flush/idex_bubble/pipe_hold:
  - NORMAL 1/1/0/0/0.
  - FLUSH 1/1/1/1/0 (PC loads the branch target).
  - STALL 0/0/0/1/0.
  - HOLD 0/0/0/0/1.
  - RST 0/0/1/1/0.
- Output priority, highest first:
  - reset=1: RST.
  - mem_busy=1: HOLD, in any state.
  - ex_branch_taken=1: FLUSH, in any state.
  - state==LU_STALL: STALL.
  - state==RUN and hz=1: STALL.
  - Otherwise: NORMAL.
- FSM (registers rem[2:0], ret_state[1:0]):
  - reset: state=RUN, rem=0, ret_state=RUN, both counters=0.
  - Any state, mem_busy=1:
    - Entering FREEZE from RUN or LU_STALL: ret_state=current state.
    - In FREEZE: stay FREEZE; rem and ret_state unchanged.
  - FREEZE, mem_busy=0:
    - Produces the output for ret_state with current inputs (branch and hz rules apply).
    - Next state is computed exactly as if in ret_state.
  - RUN:
    - ex_branch_taken: stay RUN.
    - Else if hz and LU_STALL_CYCLES>1: go LU_STALL, rem=LU_STALL_CYCLES-1.
    - Else: stay RUN.
    - hz with LU_STALL_CYCLES=1 gives a single stall cycle, stays RUN.
  - LU_STALL:
    - ex_branch_taken: abort to RUN, rem=0.
    - Else if rem==1: go RUN.
    - Else: rem=rem-1.
  - Load-use penalty is exactly LU_STALL_CYCLES non-frozen cycles. Frozen cycles do not consume rem.
- Counters:
  - Increment on the edge when the current cycle's pc_write=0 (stall_cycles) or ifid_flush=1 (flush_count), and reset=0.
  - Both saturate at all-ones.
  - reset=1 clears both; reset asserted mid-stall aborts to RUN immediately.
- Zero latency from hazard inputs to enables; one-cycle latency to state and counters.

Test Plan:
- Single-cycle load-use (LU_STALL_CYCLES=1): idex_memread=1, idex_rd=5, ifid_instr=0x00628533 (add x10,x5,x6) -> pc_write=0, ifid_write=0, idex_bubble=1 for that cycle; state stays 00; stall_cycles=1.
- No false hazards:
  - idex_rd=0 with instruction 0x00028533 -> NORMAL.
  - idex_rd=5 with ifid_instr=0x000280B7 (lui x1, rs1 field=5) -> NORMAL.
  - stall_cycles stays 0 in both cases.
- Multi-cycle stall (LU_STALL_CYCLES=3): hz in RUN -> STALL for exactly 3 cycles; state 00,01,01 then 00; stall_cycles=3.
- Freeze mid-stall (LU_STALL_CYCLES=3): mem_busy=1 for 2 cycles on the 2nd stall cycle -> HOLD for 2 cycles with state=10; then 2 more STALL cycles; stall_cycles=5.
- Branch priority: hz=1 and ex_branch_taken=1 in the same cycle -> FLUSH (ifid_flush=1, idex_bubble=1, pc_write=1); state stays 00; flush_count=1; stall_cycles=0.
- Reset mid-stall (LU_STALL_CYCLES=3): reset during the 2nd stall cycle -> RST outputs; next cycle state=00 and counters=0; NORMAL resumes.
